// File: rtl/mem_access_stage.sv
// Memory stage: EX/MEM register, data-memory req/ack access FSM with timeout,
// MEM/WB register and MEM-stage forwarding outputs.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic [3:0]  ex_rd,
  input  logic        flush,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        fwd_valid,
  output logic [3:0]  fwd_rd,
  output logic [15:0] fwd_data,
  output logic        load_pending,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        mem_err
);

  localparam int unsigned DW      = 16;
  localparam int unsigned RW      = 4;
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN   = (TIMEOUT != 0);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state;
  logic             em_valid;
  logic [DW-1:0]    em_alu;
  logic             em_mem_read;
  logic             em_mem_write;
  logic             em_reg_write;
  logic [RW-1:0]    em_rd;
  logic [CNT_W-1:0] cnt;

  logic in_access;
  logic timeout_hit;
  logic capture;
  logic cap_valid;
  logic cap_mem;
  logic read_done;

  // Stall/capture decode; the ack or timeout cycle releases the pipeline
  always_comb begin
    in_access   = (state == ACCESS);
    timeout_hit = TO_EN & in_access & ~dmem_ack & (cnt == CNT_W'(TO_LAST));
    stall_out   = in_access & ~dmem_ack & ~timeout_hit;
    capture     = ~stall_out;
    cap_valid   = ex_valid & ~flush;
    cap_mem     = cap_valid & (ex_mem_read | ex_mem_write);
    // Read+write together is treated as a write, so no rdata is taken
    read_done   = in_access & dmem_ack & em_mem_read & ~em_mem_write;
  end

  assign fwd_rd   = em_rd;
  assign fwd_data = em_alu;

  // EX/MEM register and forwarding flags, held while an access is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_valid     <= 1'b0;
      em_alu       <= '0;
      em_mem_read  <= 1'b0;
      em_mem_write <= 1'b0;
      em_reg_write <= 1'b0;
      em_rd        <= '0;
      fwd_valid    <= 1'b0;
      load_pending <= 1'b0;
    end else if (capture) begin
      em_valid     <= cap_valid;
      em_alu       <= ex_alu_result;
      em_mem_read  <= ex_mem_read;
      em_mem_write <= ex_mem_write;
      em_reg_write <= ex_reg_write;
      em_rd        <= ex_rd;
      fwd_valid    <= cap_valid & ex_reg_write & ~ex_mem_read;
      load_pending <= cap_valid & ex_reg_write & ex_mem_read;
    end
  end

  // Access FSM with registered bus outputs and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (capture) begin
      if (cap_mem) begin
        state      <= ACCESS;
        cnt        <= '0;
        dmem_req   <= 1'b1;
        dmem_we    <= ex_mem_write;
        dmem_addr  <= ex_alu_result;
        dmem_wdata <= ex_store_data;
      end else begin
        state    <= IDLE;
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // MEM/WB register and sticky timeout error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mem_err      <= 1'b0;
    end else begin
      if (capture) begin
        wb_valid     <= em_valid;
        wb_reg_write <= em_valid & em_reg_write & ~timeout_hit;
        wb_rd        <= em_rd;
        wb_data      <= read_done ? dmem_rdata : em_alu;
      end
      if (timeout_hit) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [15:0] ex_alu_result;
  logic [15:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [3:0]  ex_rd;
  logic        flush;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic        load_pending;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .flush         (flush),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .load_pending  (load_pending),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock, then settle 1 time unit past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                        input logic rd_op, input logic wr_op, input logic rw,
                        input logic [3:0] rd);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_mem_read   = rd_op;
    ex_mem_write  = wr_op;
    ex_reg_write  = rw;
    ex_rd         = rd;
  endtask

  task automatic clear_ex();
    set_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0;
    clear_ex();
    #3;
    check("rst_req",   16'(dmem_req), 16'h0);
    check("rst_stall", 16'(stall_out), 16'h0);
    check("rst_wbv",   16'(wb_valid), 16'h0);
    check("rst_err",   16'(mem_err), 16'h0);
    check("rst_fwdv",  16'(fwd_valid), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD r3 <- 0x1234
    set_ex(1'b1, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    clear_ex();
    check("add_req",    16'(dmem_req), 16'h0);
    check("add_fwdv",   16'(fwd_valid), 16'h1);
    check("add_fwdrd",  16'(fwd_rd), 16'h3);
    check("add_fwdd",   fwd_data, 16'h1234);
    check("add_wbv0",   16'(wb_valid), 16'h0);
    tick();
    check("add_wbv",    16'(wb_valid), 16'h1);
    check("add_wbrw",   16'(wb_reg_write), 16'h1);
    check("add_wbrd",   16'(wb_rd), 16'h3);
    check("add_wbd",    wb_data, 16'h1234);
    check("add_fwdv1",  16'(fwd_valid), 16'h0);

    // LW r5 @0x0040, ack in third ACCESS cycle
    set_ex(1'b1, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 4'd5);
    tick();
    clear_ex();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hBEEF;
      end
      #1;
      check($sformatf("lw_req%0d", c),   16'(dmem_req), 16'h1);
      check($sformatf("lw_we%0d", c),    16'(dmem_we), 16'h0);
      check($sformatf("lw_addr%0d", c),  dmem_addr, 16'h0040);
      check($sformatf("lw_stall%0d", c), 16'(stall_out), (c < 3) ? 16'h1 : 16'h0);
      check($sformatf("lw_lp%0d", c),    16'(load_pending), 16'h1);
      check($sformatf("lw_fwdv%0d", c),  16'(fwd_valid), 16'h0);
      check($sformatf("lw_wbv%0d", c),   16'(wb_valid), 16'h0);
      tick();
    end
    dmem_ack = 1'b0;
    check("lw_wbv",   16'(wb_valid), 16'h1);
    check("lw_wbd",   wb_data, 16'hBEEF);
    check("lw_wbrd",  16'(wb_rd), 16'h5);
    check("lw_wbrw",  16'(wb_reg_write), 16'h1);
    check("lw_reqlo", 16'(dmem_req), 16'h0);

    // SW @0x0010 data 0xA5A5, ack on first ACCESS cycle
    set_ex(1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    clear_ex();
    dmem_ack = 1'b1;
    #1;
    check("sw_req",   16'(dmem_req), 16'h1);
    check("sw_we",    16'(dmem_we), 16'h1);
    check("sw_addr",  dmem_addr, 16'h0010);
    check("sw_wdata", dmem_wdata, 16'hA5A5);
    check("sw_stall", 16'(stall_out), 16'h0);
    tick();
    dmem_ack = 1'b0;
    check("sw_wbv",   16'(wb_valid), 16'h1);
    check("sw_wbrw",  16'(wb_reg_write), 16'h0);
    check("sw_req0",  16'(dmem_req), 16'h0);

    // Back-to-back LW r1 @0x0100 then LW r2 @0x0200, two cycles each
    set_ex(1'b1, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 4'd1);
    tick();
    set_ex(1'b1, 16'h0200, 16'h0, 1'b1, 1'b0, 1'b1, 4'd2);
    #1;
    check("b2b_req1a",  16'(dmem_req), 16'h1);
    check("b2b_addr1a", dmem_addr, 16'h0100);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 16'h1111;
    #1;
    check("b2b_req1b",  16'(dmem_req), 16'h1);
    check("b2b_addr1b", dmem_addr, 16'h0100);
    tick();
    dmem_ack = 1'b0;
    clear_ex();
    #1;
    check("b2b_req2a",  16'(dmem_req), 16'h1);
    check("b2b_addr2a", dmem_addr, 16'h0200);
    check("b2b_stall",  16'(stall_out), 16'h1);
    check("b2b_wbv1",   16'(wb_valid), 16'h1);
    check("b2b_wbd1",   wb_data, 16'h1111);
    check("b2b_wbrd1",  16'(wb_rd), 16'h1);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 16'h2222;
    #1;
    check("b2b_req2b",  16'(dmem_req), 16'h1);
    check("b2b_wbv_gap", 16'(wb_valid), 16'h1);
    tick();
    dmem_ack = 1'b0;
    check("b2b_req_lo", 16'(dmem_req), 16'h0);
    check("b2b_wbv2",   16'(wb_valid), 16'h1);
    check("b2b_wbd2",   wb_data, 16'h2222);
    check("b2b_wbrd2",  16'(wb_rd), 16'h2);

    // Flush raised during ACCESS does not abort LW r6 @0x0300
    set_ex(1'b1, 16'h0300, 16'h0, 1'b1, 1'b0, 1'b1, 4'd6);
    tick();
    clear_ex();
    flush = 1'b1;
    #1;
    check("fl_stall", 16'(stall_out), 16'h1);
    check("fl_req",   16'(dmem_req), 16'h1);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 16'h6666;
    tick();
    dmem_ack = 1'b0;
    flush    = 1'b0;
    check("fl_wbv",  16'(wb_valid), 16'h1);
    check("fl_wbrw", 16'(wb_reg_write), 16'h1);
    check("fl_wbd",  wb_data, 16'h6666);
    check("fl_wbrd", 16'(wb_rd), 16'h6);

    // Timeout: LW r7 @0x0400 never acked, TIMEOUT=4
    set_ex(1'b1, 16'h0400, 16'h0, 1'b1, 1'b0, 1'b1, 4'd7);
    tick();
    clear_ex();
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("to_req%0d", c),   16'(dmem_req), 16'h1);
      check($sformatf("to_stall%0d", c), 16'(stall_out), (c < 4) ? 16'h1 : 16'h0);
      check($sformatf("to_err%0d", c),   16'(mem_err), 16'h0);
      tick();
    end
    check("to_req_lo", 16'(dmem_req), 16'h0);
    check("to_err",    16'(mem_err), 16'h1);
    check("to_wbv",    16'(wb_valid), 16'h1);
    check("to_wbrw",   16'(wb_reg_write), 16'h0);
    check("to_stall",  16'(stall_out), 16'h0);

    // Ack while idle is ignored; error stays sticky
    dmem_ack   = 1'b1;
    dmem_rdata = 16'hDEAD;
    #1;
    check("idle_ack_stall", 16'(stall_out), 16'h0);
    tick();
    dmem_ack = 1'b0;
    check("idle_ack_req", 16'(dmem_req), 16'h0);
    check("idle_ack_wbv", 16'(wb_valid), 16'h0);
    check("err_sticky",   16'(mem_err), 16'h1);

    // Asynchronous reset in the middle of an access
    set_ex(1'b1, 16'h0044, 16'h0, 1'b0, 1'b0, 1'b1, 4'd4);
    tick();
    set_ex(1'b1, 16'h0500, 16'h0, 1'b1, 1'b0, 1'b1, 4'd8);
    tick();
    clear_ex();
    check("pre_rst_req",   16'(dmem_req), 16'h1);
    check("pre_rst_stall", 16'(stall_out), 16'h1);
    check("pre_rst_wbv",   16'(wb_valid), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   16'(dmem_req), 16'h0);
    check("arst_stall", 16'(stall_out), 16'h0);
    check("arst_wbv",   16'(wb_valid), 16'h0);
    check("arst_err",   16'(mem_err), 16'h0);
    check("arst_lp",    16'(load_pending), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
